// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared types and constants for the score display path.
//   state_t      : display mode (SHOW live digits, FLASH frozen final score)
//   digit_idx_t  : scan position, 0 = ones, 1 = tens, 2 = hundreds
//   SEG_*        : seven-segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   cnt_width()  : counter width for a given terminal count, never below 1
package score_display_pkg;

   localparam logic [0:0] ST_SHOW  = 1'b0;
   localparam logic [0:0] ST_FLASH = 1'b1;

   typedef enum logic [0:0] {
      SHOW  = ST_SHOW,
      FLASH = ST_FLASH
   } state_t;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic int cnt_width(input int terminal);
      return ($clog2(terminal) < 1) ? 1 : $clog2(terminal);
   endfunction

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// bcd_to_7seg
// Combinational decoder for one display digit.
//   bcd   : 4-bit digit value; anything above 9 renders as a dash
//   blank : forces all segments off (leading-zero suppression)
//   seg   : segments {g,f,e,d,c,b,a}, active-high
module bcd_to_7seg
   import score_display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   // NOTE: assign a default before the case so every path drives seg; a
   // missing branch would otherwise infer a latch.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
      if (blank) seg = SEG_BLANK;
   end

endmodule

// File: rtl/score_display.sv
// score_display
// Drives a 3-digit multiplexed seven-segment display from the score tracker.
// Shows the live digits with leading-zero blanking; on a game-over rising
// edge it freezes the final score and flashes it for a fixed time.
//   clk            : system clock
//   nRst           : synchronous, active-low reset
//   bcd_ones/tens/hundreds : live BCD digits from the tracker
//   isGameComplete : game-over level
//   seg            : registered segments {g,f,e,d,c,b,a}, active-high
//   dig_sel        : registered one-hot digit enable (bit0 ones .. bit2 hundreds)
//   flashing       : high while the final score is being flashed
module score_display
   import score_display_pkg::*;
#(
   parameter int SCAN_CYCLES   = 1000,
   parameter int FLASH_CYCLES  = 25000,
   parameter int FLASH_TOGGLES = 6
) (
   input  logic       clk,
   input  logic       nRst,
   input  logic [3:0] bcd_ones,
   input  logic [3:0] bcd_tens,
   input  logic [3:0] bcd_hundreds,
   input  logic       isGameComplete,
   output logic [6:0] seg,
   output logic [2:0] dig_sel,
   output logic       flashing
);

   localparam int SCAN_W  = cnt_width(SCAN_CYCLES);
   localparam int FLASH_W = cnt_width(FLASH_CYCLES);
   localparam int TOG_W   = cnt_width(FLASH_TOGGLES);

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_CYCLES - 1);
   localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(FLASH_TOGGLES - 1);

   state_t             state;
   logic               prev_gc;
   logic               rise;
   logic               phase;
   logic [SCAN_W-1:0]  scan_cnt;
   logic [FLASH_W-1:0] flash_cnt;
   logic [TOG_W-1:0]   tog_cnt;
   digit_idx_t         idx;
   logic [3:0]         h_ones;
   logic [3:0]         h_tens;
   logic [3:0]         h_hund;

   logic [3:0]         cur_bcd;
   logic               cur_blank;
   logic [2:0]         cur_sel;
   logic [6:0]         cur_seg;

   assign rise     = isGameComplete & ~prev_gc;
   assign flashing = (state == FLASH);

   // Select the held digit for the current scan slot and decide blanking.
   always_comb begin
      cur_bcd   = h_ones;
      cur_blank = 1'b0;
      cur_sel   = 3'b001;
      case (idx)
         2'd1: begin
            cur_bcd   = h_tens;
            cur_blank = (h_hund == 4'd0) && (h_tens == 4'd0);
            cur_sel   = 3'b010;
         end
         2'd2: begin
            cur_bcd   = h_hund;
            cur_blank = (h_hund == 4'd0);
            cur_sel   = 3'b100;
         end
         default: ;
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd   (cur_bcd),
      .blank (cur_blank),
      .seg   (cur_seg)
   );

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!nRst) begin
         state     <= SHOW;
         prev_gc   <= 1'b0;
         phase     <= 1'b0;
         scan_cnt  <= '0;
         flash_cnt <= '0;
         tog_cnt   <= '0;
         idx       <= 2'd0;
         h_ones    <= 4'd0;
         h_tens    <= 4'd0;
         h_hund    <= 4'd0;
         seg       <= SEG_BLANK;
         dig_sel   <= 3'b000;
      end else begin
         prev_gc <= isGameComplete;

         // Scanning runs in every state and never pauses.
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end

         // Blank half of the flash keeps dig_sel scanning but drops segments.
         seg     <= phase ? SEG_BLANK : cur_seg;
         dig_sel <= cur_sel;

         case (state)
            SHOW: begin
               // The tracker swaps to the high score on the rise edge, so the
               // held digits keep the final score instead of loading.
               if (rise) begin
                  state <= FLASH;
               end else begin
                  h_ones <= bcd_ones;
                  h_tens <= bcd_tens;
                  h_hund <= bcd_hundreds;
               end
            end
            FLASH: begin
               if (flash_cnt == FLASH_LAST) begin
                  flash_cnt <= '0;
                  if (tog_cnt == TOG_LAST) begin
                     state   <= SHOW;
                     tog_cnt <= '0;
                     phase   <= 1'b0;
                  end else begin
                     tog_cnt <= tog_cnt + TOG_W'(1);
                     phase   <= ~phase;
                  end
               end else begin
                  flash_cnt <= flash_cnt + FLASH_W'(1);
               end
            end
            default: state <= SHOW;
         endcase
      end
   end

endmodule

// File: tb/tb_score_display.sv
// tb_score_display
// Directed bench for score_display with SCAN_CYCLES=4, FLASH_CYCLES=8,
// FLASH_TOGGLES=4. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, one unit clear of the active edge.
module tb_score_display;

   localparam int SCAN = 4;
   localparam int FC   = 8;
   localparam int FT   = 4;

   logic       clk = 1'b0;
   logic       nRst;
   logic [3:0] bcd_ones, bcd_tens, bcd_hundreds;
   logic       isGameComplete;
   logic [6:0] seg;
   logic [2:0] dig_sel;
   logic       flashing;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // edges since the most recent reset release

   always #5 clk = ~clk;

   score_display #(
      .SCAN_CYCLES   (SCAN),
      .FLASH_CYCLES  (FC),
      .FLASH_TOGGLES (FT)
   ) dut (
      .clk            (clk),
      .nRst           (nRst),
      .bcd_ones       (bcd_ones),
      .bcd_tens       (bcd_tens),
      .bcd_hundreds   (bcd_hundreds),
      .isGameComplete (isGameComplete),
      .seg            (seg),
      .dig_sel        (dig_sel),
      .flashing       (flashing)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      bcd_hundreds = h;
      bcd_tens     = t;
      bcd_ones     = o;
   endtask

   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(input logic [2:0] sel, input logic [3:0] h,
                                          input logic [3:0] t, input logic [3:0] o);
      case (sel)
         3'b001: return dec(o);
         3'b010: return (h == 4'd0 && t == 4'd0) ? 7'h00 : dec(t);
         3'b100: return (h == 4'd0) ? 7'h00 : dec(h);
         default: return 7'h00;
      endcase
   endfunction

   // dig_sel after edge n (n >= 1) of a scan started from reset.
   function automatic logic [2:0] sel_at(input int n);
      return 3'b001 << (((n - 1) / SCAN) % 3);
   endfunction

   // Wait (bounded) for a digit slot, then check its segments.
   task automatic check_slot(input string tag, input logic [2:0] sel, input logic [6:0] exp);
      int n = 0;
      while (dig_sel !== sel && n < 16) begin
         tick();
         n++;
      end
      check({tag, "_sel_reached"}, {5'd0, dig_sel}, {5'd0, sel});
      check(tag, {1'b0, seg}, {1'b0, exp});
   endtask

   // Caller has already driven the rise; this takes edge E and the 33 after it.
   // At m == lo_m the game-complete level drops and the live digits change; at
   // m == hi_m it rises again. Neither may disturb the sequence.
   task automatic run_flash(input string tag, input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, input int lo_m, input int hi_m);
      logic blank;
      tick();
      check({tag, "_flash_enter"}, {7'd0, flashing}, 8'd1);
      for (int m = 1; m <= 33; m++) begin
         if (m == lo_m) begin
            isGameComplete = 1'b0;
            set_digits(4'd8, 4'd8, 4'd8);
         end
         if (m == hi_m) isGameComplete = 1'b1;
         tick();
         blank = (m >= 9 && m <= 16) || (m >= 25 && m <= 32);
         check($sformatf("%s_flashing_m%0d", tag, m), {7'd0, flashing}, {7'd0, (m < FC * FT)});
         check($sformatf("%s_dig_sel_m%0d", tag, m), {5'd0, dig_sel}, {5'd0, sel_at(cyc)});
         check($sformatf("%s_seg_m%0d", tag, m), {1'b0, seg},
               {1'b0, blank ? 7'h00 : exp_seg(sel_at(cyc), h, t, o)});
      end
   endtask

   initial begin
      // Reset with arbitrary inputs
      nRst           = 1'b0;
      isGameComplete = 1'b0;
      set_digits(4'd9, 4'd6, 4'd2);
      ticks(3);
      check("rst_seg",      {1'b0, seg},     8'h00);
      check("rst_dig_sel",  {5'd0, dig_sel}, 8'h00);
      check("rst_flashing", {7'd0, flashing}, 8'h00);

      // Release: first edge shows ones slot with held 0
      set_digits(4'd1, 4'd3, 4'd7);
      nRst = 1'b1;
      cyc  = 0;
      tick();
      check("rel_dig_sel_1", {5'd0, dig_sel}, 8'h01);
      check("rel_seg_1",     {1'b0, seg},     8'h3F);
      ticks(3);
      check("rel_dig_sel_4",  {5'd0, dig_sel}, 8'h01);
      tick();
      check("rel_dig_sel_5",  {5'd0, dig_sel}, 8'h02);
      ticks(4);
      check("rel_dig_sel_9",  {5'd0, dig_sel}, 8'h04);
      ticks(4);
      check("rel_dig_sel_13", {5'd0, dig_sel}, 8'h01);

      // Digits 1,3,7
      check_slot("d137_ones", 3'b001, 7'h07);
      check_slot("d137_tens", 3'b010, 7'h4F);
      check_slot("d137_hund", 3'b100, 7'h06);

      // Digits 0,0,5
      set_digits(4'd0, 4'd0, 4'd5);
      ticks(3);
      check_slot("d005_hund", 3'b100, 7'h00);
      check_slot("d005_tens", 3'b010, 7'h00);
      check_slot("d005_ones", 3'b001, 7'h6D);

      // Digits 0,4,0
      set_digits(4'd0, 4'd4, 4'd0);
      ticks(3);
      check_slot("d040_hund", 3'b100, 7'h00);
      check_slot("d040_tens", 3'b010, 7'h66);
      check_slot("d040_ones", 3'b001, 7'h3F);

      // Game over: score 0,2,3 then high score 0,4,5 on the rise edge
      set_digits(4'd0, 4'd2, 4'd3);
      ticks(3);
      check_slot("d023_ones", 3'b001, 7'h4F);
      check_slot("d023_tens", 3'b010, 7'h5B);
      isGameComplete = 1'b1;
      set_digits(4'd0, 4'd4, 4'd5);
      run_flash("go", 4'd0, 4'd2, 4'd3, 0, 0);
      ticks(2);
      check("go_after_flashing", {7'd0, flashing}, 8'h00);
      check_slot("hs_ones", 3'b001, 7'h6D);
      check_slot("hs_tens", 3'b010, 7'h66);
      check_slot("hs_hund", 3'b100, 7'h00);

      // Game-complete toggling and digit changes during FLASH are ignored
      isGameComplete = 1'b0;
      set_digits(4'd1, 4'd0, 4'd9);
      ticks(3);
      check_slot("d109_tens", 3'b010, 7'h3F);
      isGameComplete = 1'b1;
      set_digits(4'd2, 4'd2, 4'd2);
      run_flash("tog", 4'd1, 4'd0, 4'd9, 5, 12);
      ticks(2);
      check("tog_after_flashing", {7'd0, flashing}, 8'h00);
      check_slot("d888_ones", 3'b001, 7'h7F);

      // Illegal digit renders as a dash
      isGameComplete = 1'b0;
      set_digits(4'd0, 4'd0, 4'hC);
      ticks(3);
      check_slot("illegal_ones", 3'b001, 7'h40);
      check_slot("illegal_tens", 3'b010, 7'h00);

      // Reset mid-FLASH aborts at once
      isGameComplete = 1'b1;
      tick();
      ticks(9);
      check("midrst_in_flash", {7'd0, flashing}, 8'h01);
      nRst = 1'b0;
      tick();
      check("midrst_flashing", {7'd0, flashing}, 8'h00);
      check("midrst_seg",      {1'b0, seg},      8'h00);
      check("midrst_dig_sel",  {5'd0, dig_sel},  8'h00);

      // Game-complete already high out of reset counts as a rise
      nRst = 1'b1;
      cyc  = 0;
      tick();
      check("postrst_rise_flashing", {7'd0, flashing}, 8'h01);
      check("postrst_dig_sel",       {5'd0, dig_sel},  8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
